// File: rtl/dmem_pkg.sv
// Shared constants, types and lane-merge helper for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 16384;
  localparam logic [31:0] DMEM_MMIO_ADDR   = 32'h0001_0000;

  localparam logic [3:0] MASK_SB = 4'h1;
  localparam logic [3:0] MASK_SH = 4'h3;
  localparam logic [3:0] MASK_SW = 4'hF;

  // tohost code: 1 = pass, any other nonzero value = fail code
  localparam logic [31:0] HALT_PASS = 32'h1;

  typedef enum logic [1:0] {
    RD_ZERO  = 2'd0,
    RD_ARRAY = 2'd1,
    RD_MMIO  = 2'd2
  } rd_src_e;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised byte-lane-writable storage with a registered, write-first read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [3:0]                     i_be,
  input  logic [31:0]                    i_wdata,
  input  logic                           i_re,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_re) r_rdata <= merge_lanes(r_mem[i_idx], i_wdata, i_be);
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: decode, sticky error, saturating store counter.
// Optional tohost/halt register enabled by defining DMEM_MMIO_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter logic [31:0] MMIO_ADDR   = DMEM_MMIO_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        addr_err,
  output logic [31:0] wr_count,
  output logic        halt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic          w_in_range;
  logic          w_is_mmio;
  logic          w_has_wr;
  logic          w_acc_ok;
  logic [3:0]    w_arr_be;
  logic          w_arr_re;
  logic [31:0]   w_arr_rdata;
  logic [31:0]   w_mmio_rdata;
  logic          r_addr_err;
  logic [31:0]   r_wr_count;
  rd_src_e       r_src;

  assign w_in_range = {32'd0, data_addr} < (64'(DEPTH_WORDS) << 2);
  assign w_has_wr   = |data_write;
  assign w_acc_ok   = w_in_range | w_is_mmio;
  assign w_arr_be   = (rst || !w_in_range) ? '0 : data_write;
  assign w_arr_re   = data_read && w_in_range && !rst;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .i_idx   (data_addr[AW+1:2]),
    .i_be    (w_arr_be),
    .i_wdata (data_in),
    .i_re    (w_arr_re),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
      r_wr_count <= '0;
      r_src      <= RD_ZERO;
    end else begin
      if ((w_has_wr || data_read) && !w_acc_ok) r_addr_err <= 1'b1;
      if (w_has_wr && w_acc_ok && (r_wr_count != '1)) r_wr_count <= r_wr_count + 32'd1;
      if (data_read) begin
        if (w_in_range)     r_src <= RD_ARRAY;
        else if (w_is_mmio) r_src <= RD_MMIO;
        else                r_src <= RD_ZERO;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] r_tohost;
  logic [31:0] r_mmio_rdata;
  logic        r_halt;
  logic [31:0] w_tohost_new;
  logic        w_tohost_we;

  assign w_is_mmio    = data_addr[31:2] == MMIO_ADDR[31:2];
  assign w_tohost_new = merge_lanes(r_tohost, data_in, data_write);
  // once halted, tohost is frozen but the store is still counted above
  assign w_tohost_we  = w_is_mmio && w_has_wr && !r_halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tohost     <= '0;
      r_mmio_rdata <= '0;
      r_halt       <= 1'b0;
    end else begin
      if (w_tohost_we) begin
        r_tohost <= w_tohost_new;
        if (w_tohost_new != '0) r_halt <= 1'b1;
      end
      if (data_read && w_is_mmio) r_mmio_rdata <= w_tohost_we ? w_tohost_new : r_tohost;
    end
  end

  assign w_mmio_rdata = r_mmio_rdata;
  assign halt         = r_halt;
`else
  assign w_is_mmio    = 1'b0;
  assign w_mmio_rdata = '0;
  assign halt         = 1'b0;
`endif

  always_comb begin
    data_out = '0;
    case (r_src)
      RD_ARRAY: data_out = w_arr_rdata;
      RD_MMIO:  data_out = w_mmio_rdata;
      default:  data_out = '0;
    endcase
  end

  assign addr_err = r_addr_err;
  assign wr_count = r_wr_count;

endmodule
